mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the 16-bit WISC pipeline, directly downstream of the 16-bit ALU. Captures the ALU result, store data and destination info each cycle. Runs LW/SW (opcodes 8/9) against a data memory with a request/acknowledge handshake, stalling upstream while a transaction is open. Delivers one writeback record per retired instruction.

## Interface
- TIMEOUT, 15: cycles an open request may wait for `mem_ack` before abort; range 1..15; used only with `MEM_TIMEOUT_EN`.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; this is the only reset.
- ex_valid  in  1  an instruction is presented this cycle.
- ex_opcode  in  4  instruction opcode.
- ex_alu_result  in  16  ALU output; the effective address for LW/SW.
- ex_store_data  in  16  SW data (rt value).
- ex_rd  in  4  destination register.
- ex_reg_wen  in  1  instruction writes the register file.
- stall  out  1  upstream must hold its outputs; `ex_valid` is ignored while high.
- mem_req  out  1  data-memory request.
- mem_wr  out  1  1 = write (SW), 0 = read (LW).
- mem_addr  out  16  word-aligned address.
- mem_wdata  out  16  store data.
- mem_ack  in  1  memory completes the open request this cycle.
- mem_rdata  in  16  read data, valid with `mem_ack`.
- wb_valid  out  1  writeback record valid; one-cycle pulse.
- wb_data  out  16  result to write.
- wb_rd  out  4  destination register.
- wb_reg_wen  out  1  register write enable.
- wb_hlt  out  1  retired instruction is HLT.
- mem_err  out  1  retired record was aborted by timeout.

## Operation
- FSM states: IDLE, BUSY.
- Accept condition: `ex_valid && !stall && !halted`.
- Accepting a non-memory op (opcode not 8/9):
  - Next cycle: `wb_valid`=1, `wb_data`=`ex_alu_result`, `wb_rd`/`wb_reg_wen` registered from the inputs.
  - FSM stays in IDLE.
- Accepting LW/SW:
  - Latch `mem_addr` = {`ex_alu_result`[15:1], 0}, `mem_wr` = (opcode==9), `mem_wdata` = `ex_store_data`.
  - FSM goes to BUSY.
- In BUSY:
  - `mem_req`=1; `mem_addr`, `mem_wr` and `mem_wdata` are held stable.
  - When `mem_ack` is sampled high, next cycle: state=IDLE, `mem_req`=0, `wb_valid`=1.
  - LW record: `wb_data`=`mem_rdata` (captured at ack), `wb_reg_wen`=latched `ex_reg_wen`.
  - SW record: `wb_data`=`mem_addr`, `wb_reg_wen`=0 regardless of input.
- `stall` = (state==BUSY), combinational from state.
- `mem_ack` while IDLE: ignored, no record produced.
- HLT (opcode F):
  - Retires as a non-memory op with `wb_hlt`=1, `wb_reg_wen`=0.
  - Sets sticky `halted`; every later `ex_valid` is ignored until reset.
- `wb_valid`=0 in any cycle without a retirement.
- When `wb_valid`=0, the other wb_* outputs hold their last values; `wb_hlt` and `mem_err` are 0.

## Timing
- Reset (async, immediate): state=IDLE, `halted`=0.
- Reset value 0 on every output: `stall`, `mem_req`, `mem_wr`, `mem_addr`, `mem_wdata`, `wb_valid`, `wb_data`, `wb_rd`, `wb_reg_wen`, `wb_hlt`, `mem_err`.
- Reset mid-BUSY: the open transaction is dropped and no record is produced.
- Non-memory latency: 1 cycle accept→`wb_valid`.
- Memory latency: `mem_req` rises the cycle after accept.
  - If `mem_ack` arrives in the k-th cycle of request (k≥1), `wb_valid` occurs k+1 cycles after accept.
  - Minimum is 2 cycles.
- `stall` falls in the same cycle `wb_valid` rises for a memory op, so a new instruction can be accepted in that cycle.
- Throughput: back-to-back non-memory ops at 1 per cycle; at most one memory transaction open.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack`.
  - When it reaches TIMEOUT: abort; next cycle state=IDLE, `mem_req`=0, `wb_valid`=1, `mem_err`=1, `wb_reg_wen`=0, `wb_data`=0.
  - `mem_ack` in the same cycle the count reaches TIMEOUT wins: normal completion, no error.
- `MEM_TIMEOUT_EN` undefined: BUSY waits indefinitely; `mem_err` is tied 0; the TIMEOUT parameter is unused.

## Structure
- Shared package `wisc_pkg` holds:
  - opcode constants OP_LW=4'h8, OP_SW=4'h9, OP_HLT=4'hF;
  - the state encoding (IDLE, BUSY);
  - the data width constant 16.
- One sub-module, `mem_watchdog` (counter + expiry flag, enable/clear inputs), instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- ADD with `ex_alu_result`=16'h1234, rd=3, reg_wen=1 → next cycle `wb_valid`=1, `wb_data`=16'h1234, `wb_rd`=3, `stall` never asserted.
- LW, `ex_alu_result`=16'h0041, `mem_ack` on 3rd request cycle with `mem_rdata`=16'hBEEF:
  - `mem_addr`=16'h0040, `mem_wr`=0;
  - `stall` high 3 cycles;
  - `wb_data`=16'hBEEF, `wb_reg_wen`=1 at accept+4.
- SW, addr 16'h0010, data 16'h00AA, immediate ack → `mem_wr`=1, `mem_wdata`=16'h00AA, `wb_reg_wen`=0 at accept+2; an ADD held upstream is accepted in the cycle `stall` falls.
- HLT followed by ADD held valid → one record with `wb_hlt`=1; the ADD is never retired.
- Reset pulsed during BUSY → all outputs 0 immediately, no `wb_valid`; a later LW completes normally.
- `MEM_TIMEOUT_EN`, TIMEOUT=4, no ack → `mem_req` high 4 cycles, then `wb_valid`=1, `mem_err`=1, `wb_reg_wen`=0; repeat with ack in the 4th cycle → normal completion, `mem_err`=0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions: opcode constants, datapath width and the
// memory-access stage state encoding.
package wisc_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Watchdog for an open data-memory request: counts waiting cycles and flags
// expiry in the cycle the count would reach LIMIT.
module mem_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  // Expiry is flagged on the cycle whose increment reaches LIMIT, so the
  // request is held for exactly LIMIT cycles before the abort takes effect.
  assign expired = enable && (count == 4'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// WISC memory-access stage: retires ALU ops directly and runs LW/SW through a
// req/ack data-memory handshake. Define MEM_TIMEOUT_EN to abort stuck requests.
module mem_access_stage
  import wisc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [3:0]        ex_rd,
  input  logic              ex_reg_wen,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        wb_rd,
  output logic              wb_reg_wen,
  output logic              wb_hlt,
  output logic              mem_err
);

  mem_state_t state, state_next;
  logic       halted;
  logic [3:0] pend_rd;
  logic       pend_reg_wen;
  logic       accept;
  logic       is_mem;
  logic       is_hlt;
  logic       ack_done;
  logic       abort;

  assign stall    = (state == BUSY);
  assign mem_req  = (state == BUSY);
  assign accept   = ex_valid && !stall && !halted;
  assign is_mem   = (ex_opcode == OP_LW) || (ex_opcode == OP_SW);
  assign is_hlt   = (ex_opcode == OP_HLT);
  assign ack_done = (state == BUSY) && mem_ack;

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept && is_mem),
    .enable  ((state == BUSY) && !mem_ack),
    .expired (abort)
  );
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem) state_next = BUSY;
      BUSY:    if (mem_ack || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Records are single-cycle pulses; wb_data/wb_rd/wb_reg_wen keep their last
  // value between records while the flag outputs fall back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      pend_rd      <= '0;
      pend_reg_wen <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_wen   <= 1'b0;
      wb_hlt       <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_hlt   <= 1'b0;
      mem_err  <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid   <= 1'b1;
        wb_data    <= ex_alu_result;
        wb_rd      <= ex_rd;
        wb_reg_wen <= ex_reg_wen && !is_hlt;
        wb_hlt     <= is_hlt;
        if (is_hlt) halted <= 1'b1;
      end else if (accept) begin
        mem_addr     <= {ex_alu_result[DATA_W-1:1], 1'b0};
        mem_wr       <= (ex_opcode == OP_SW);
        mem_wdata    <= ex_store_data;
        pend_rd      <= ex_rd;
        pend_reg_wen <= ex_reg_wen;
      end
      // A store reports its address as the record data and never writes back.
      if (ack_done) begin
        wb_valid   <= 1'b1;
        wb_rd      <= pend_rd;
        wb_data    <= mem_wr ? mem_addr : mem_rdata;
        wb_reg_wen <= !mem_wr && pend_reg_wen;
      end else if (abort) begin
        wb_valid   <= 1'b1;
        wb_rd      <= pend_rd;
        wb_data    <= '0;
        wb_reg_wen <= 1'b0;
        mem_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a cycle-level reference model predicts
// stall windows and writeback records; a monitor compares what the DUT presents.
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_alu_result;
  logic [15:0] ex_store_data;
  logic [3:0]  ex_rd;
  logic        ex_reg_wen;
  logic        stall;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_reg_wen;
  logic        wb_hlt;
  logic        mem_err;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_wen    (ex_reg_wen),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_reg_wen    (wb_reg_wen),
    .wb_hlt        (wb_hlt),
    .mem_err       (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [3:0]  rd;
    logic        wen;
    logic        hlt;
    logic        err;
  } wb_rec_t;

  wb_rec_t     sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  // Reference model state; cycle n is the clock period whose negedge bumps cyc.
  int          cyc = 0;
  int          busy_end = -1;
  int          ack_cyc = -1;
  bit          halted_m = 1'b0;
  bit          exp_stall = 1'b0;
  logic [15:0] pend_addr, pend_wdata, pend_rdata;
  logic        pend_wr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    exp_stall = (cyc <= busy_end);
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    if (cyc == ack_cyc) begin
      mem_ack   = 1'b1;
      mem_rdata = pend_rdata;
    end else if (!exp_stall && $urandom_range(0, 5) == 0) begin
      mem_ack = 1'b1;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      stepCycle();
      ex_valid      = 1'b0;
      ex_opcode     = 4'($urandom);
      ex_alu_result = 16'($urandom);
      ex_store_data = 16'($urandom);
      ex_rd         = 4'($urandom);
      ex_reg_wen    = 1'($urandom);
    end
  endtask

  // Present one instruction, holding it until the model says it is taken.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] sd,
                               input logic [3:0] rd, input logic wen, input int k,
                               input logic [15:0] rdata, input int max_cycles);
    bit done = 1'b0;
    int n = 0;
    wb_rec_t r;
    while (!done && n < max_cycles) begin
      stepCycle();
      ex_valid      = 1'b1;
      ex_opcode     = op;
      ex_alu_result = alu;
      ex_store_data = sd;
      ex_rd         = rd;
      ex_reg_wen    = wen;
      if (!exp_stall && !halted_m) begin
        done  = 1'b1;
        r.rd  = rd;
        r.hlt = 1'b0;
        r.err = 1'b0;
        if (op == 4'h8 || op == 4'h9) begin
          pend_addr  = alu & 16'hFFFE;
          pend_wr    = (op == 4'h9);
          pend_wdata = sd;
          pend_rdata = rdata;
          if (TO_EN && k > TO) begin
            busy_end = cyc + TO;
            ack_cyc  = -1;
            r.err    = 1'b1;
            r.data   = 16'h0000;
            r.wen    = 1'b0;
          end else begin
            busy_end = cyc + k;
            ack_cyc  = cyc + k;
            r.data   = pend_wr ? pend_addr : rdata;
            r.wen    = !pend_wr && wen;
          end
          r.cyc = busy_end + 1;
        end else begin
          r.cyc  = cyc + 1;
          r.data = alu;
          r.hlt  = (op == 4'hF);
          r.wen  = wen && (op != 4'hF);
          if (op == 4'hF) halted_m = 1'b1;
        end
        sb.push_back(r);
      end
      n++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    cyc++;
    rst_n     = 1'b0;
    ex_valid  = 1'b0;
    mem_ack   = 1'b0;
    sb.delete();
    busy_end  = -1;
    ack_cyc   = -1;
    halted_m  = 1'b0;
    exp_stall = 1'b0;
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_wb_rd", wb_rd, 0);
    checkOutput("rst_wb_reg_wen", wb_reg_wen, 0);
    checkOutput("rst_wb_hlt", wb_hlt, 0);
    checkOutput("rst_mem_err", mem_err, 0);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT against the model each cycle, away from posedge.
  initial begin
    wb_rec_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        checkOutput("stall", stall, exp_stall);
        checkOutput("mem_req", mem_req, exp_stall);
        if (exp_stall) begin
          checkOutput("mem_addr", mem_addr, pend_addr);
          checkOutput("mem_wr", mem_wr, pend_wr);
          checkOutput("mem_wdata", mem_wdata, pend_wdata);
        end
        if (wb_valid) begin
          if (sb.size() == 0) begin
            checkOutput("wb_unexpected", wb_valid, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("wb_cycle", cyc, e.cyc);
            checkOutput("wb_data", wb_data, e.data);
            checkOutput("wb_rd", wb_rd, e.rd);
            checkOutput("wb_reg_wen", wb_reg_wen, e.wen);
            checkOutput("wb_hlt", wb_hlt, e.hlt);
            checkOutput("mem_err", mem_err, e.err);
          end
        end else begin
          checkOutput("wb_hlt_idle", wb_hlt, 0);
          checkOutput("mem_err_idle", mem_err, 0);
          if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            checkOutput("wb_missing", wb_valid, 1);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    int         k;
    int         guard;
    rst_n         = 1'b1;
    ex_valid      = 1'b0;
    ex_opcode     = '0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_rd         = '0;
    ex_reg_wen    = 1'b0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    #1 rst_n = 1'b0;
    doReset();
    mon_en = 1'b1;
    $display("[TB] directed scenarios");

    applyStimulus(4'h0, 16'h1234, 16'h0000, 4'd3, 1'b1, 1, 16'h0000, 4);
    idleCycles(2);
    applyStimulus(4'h8, 16'h0041, 16'h0000, 4'd5, 1'b1, 3, 16'hBEEF, 4);
    idleCycles(5);
    applyStimulus(4'h9, 16'h0010, 16'h00AA, 4'd6, 1'b1, 1, 16'h0000, 4);
    applyStimulus(4'h1, 16'h5555, 16'h0000, 4'd7, 1'b1, 1, 16'h0000, 8);
    idleCycles(2);
    applyStimulus(4'h8, 16'h0100, 16'h0000, 4'd2, 1'b1, TO + 3, 16'h1111, 4);
    idleCycles(TO + 5);
    applyStimulus(4'h8, 16'h0102, 16'h0000, 4'd2, 1'b1, TO, 16'h2222, 4);
    idleCycles(TO + 3);
    applyStimulus(4'h8, 16'h0200, 16'h0000, 4'd4, 1'b1, 6, 16'h3333, 4);
    idleCycles(1);
    doReset();
    applyStimulus(4'h8, 16'h0203, 16'h0000, 4'd4, 1'b1, 2, 16'h4444, 4);
    idleCycles(4);
    applyStimulus(4'hF, 16'h0F0F, 16'h0000, 4'd1, 1'b1, 1, 16'h0000, 4);
    applyStimulus(4'h0, 16'h7777, 16'h0000, 4'd2, 1'b1, 1, 16'h0000, 4);
    doReset();

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 4'h8;
        2:       op = 4'h9;
        default: op = 4'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 99) == 0) op = 4'hF;
      if ($urandom_range(0, 4) == 0 && op < 4'h8) op = 4'($urandom_range(10, 14));
      k = $urandom_range(1, TO_EN ? 7 : 6);
      applyStimulus(op, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), k, 16'($urandom), 10);
      if (op == 4'hF) begin
        applyStimulus(4'h2, 16'($urandom), 16'h0000, 4'($urandom), 1'b1, 1, 16'h0000, 3);
        doReset();
      end else if ($urandom_range(0, 39) == 0) begin
        idleCycles(1);
        doReset();
      end else if ($urandom_range(0, 3) == 0) begin
        idleCycles($urandom_range(1, 3));
      end
    end

    guard = 0;
    while (sb.size() > 0 && guard < 30) begin
      idleCycles(1);
      guard++;
    end
    idleCycles(2);
    checkOutput("drain_pending", sb.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
